// File: rtl/axis_rr_arb.sv
// Packet-granular round-robin arbiter: shares one AXI-stream output among NUM inputs,
// holding each grant until the granted packet's tlast beat is accepted.
module axis_rr_arb #(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int IDW   = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM*WIDTH-1:0] s_axis_tdata,
  input  logic [NUM-1:0]       s_axis_tvalid,
  input  logic [NUM-1:0]       s_axis_tlast,
  output logic [NUM-1:0]       s_axis_tready,
  output logic [WIDTH-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic [IDW-1:0]       m_axis_tid,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic [15:0]          pkt_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [IDW-1:0]   r_grant, w_grant_next;
  logic [IDW-1:0]   r_last, w_last_next;
  logic [IDW-1:0]   w_pick;
  logic [15:0]      r_pkt_cnt, w_pkt_cnt_next;
  logic [WIDTH-1:0] w_data [NUM];
  logic             w_busy;
  logic             w_xfer_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_req
      assign w_data[gi]        = s_axis_tdata[gi*WIDTH +: WIDTH];
      assign s_axis_tready[gi] = w_busy && (r_grant == IDW'(gi)) && m_axis_tready;
    end
  endgenerate

  assign w_busy        = (r_state == ST_BUSY);
  assign m_axis_tvalid = w_busy && s_axis_tvalid[r_grant];
  assign m_axis_tdata  = w_data[r_grant];
  assign m_axis_tlast  = s_axis_tlast[r_grant];
  assign m_axis_tid    = r_grant;
  assign busy          = w_busy;
  assign pkt_cnt       = r_pkt_cnt;
  assign w_xfer_last   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Scan downward so the closest requester after r_last is the final assignment.
  always_comb begin : p_pick
    int pos;
    w_pick = '0;
    pos    = 0;
    for (int k = NUM; k >= 1; k--) begin
      pos = (int'(r_last) + k) % NUM;
      if (s_axis_tvalid[pos[IDW-1:0]]) w_pick = pos[IDW-1:0];
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_last_next    = r_last;
    w_pkt_cnt_next = r_pkt_cnt;
    case (r_state)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          w_grant_next = w_pick;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_xfer_last) begin
          w_last_next    = r_grant;
          w_pkt_cnt_next = r_pkt_cnt + 16'd1;
          w_state_next   = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_last    <= IDW'(NUM - 1);
      r_pkt_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_last    <= w_last_next;
      r_pkt_cnt <= w_pkt_cnt_next;
    end
  end

endmodule

// File: tb/tb_axis_rr_arb.sv
// Bench for axis_rr_arb: directed scenarios plus randomized traffic, every cycle
// compared against a packet-level arbitration model.
module tb_axis_rr_arb;
  localparam int WIDTH = 32;
  localparam int NUM   = 4;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM*WIDTH-1:0] s_axis_tdata;
  logic [NUM-1:0]       s_axis_tvalid;
  logic [NUM-1:0]       s_axis_tlast;
  logic [NUM-1:0]       s_axis_tready;
  logic [WIDTH-1:0]     m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic [IDW-1:0]       m_axis_tid;
  logic                 m_axis_tready;
  logic                 busy;
  logic [15:0]          pkt_cnt;

  axis_rr_arb #(.WIDTH(WIDTH), .NUM(NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tready(m_axis_tready), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Source state: remaining beats of the current packet, beat sequence number
  int rem [NUM];
  int len [NUM];
  int seq [NUM];
  bit gate [NUM];
  bit reload [NUM];
  bit rnd [NUM];

  // Reference model: who owns the channel, who was served last, packets done
  int m_cur, m_prev, m_in;
  int unsigned m_cnt;

  // Per-scenario logs
  int vq[$], tidq[$], xq[$], cq[$], pq[$];
  logic [31:0] dq[$];
  int tk, busy_n;
  logic [NUM-1:0] rdy_or;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_cur = 0; m_prev = NUM - 1; m_in = 0; m_cnt = 0;
  endtask

  task automatic src_clear();
    for (int i = 0; i < NUM; i++) begin
      rem[i] = 0; len[i] = 0; seq[i] = 0; gate[i] = 1'b1; reload[i] = 1'b0; rnd[i] = 1'b0;
    end
  endtask

  task automatic src_set(input int i, input int l, input bit rl);
    rem[i] = l; len[i] = l; reload[i] = rl; gate[i] = 1'b1;
  endtask

  task automatic clr_log();
    vq.delete(); tidq.delete(); xq.delete(); cq.delete(); pq.delete(); dq.delete();
    tk = 0; busy_n = 0; rdy_or = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      s_axis_tvalid[i] = (rem[i] > 0) && gate[i];
      s_axis_tlast[i]  = (rem[i] == 1);
      s_axis_tdata[i*WIDTH +: WIDTH] = 32'(i * 4096 + seq[i]);
    end
  endtask

  task automatic tick();
    logic [NUM-1:0] hs;
    logic [NUM-1:0] exp_rdy;
    logic exp_vld;
    bit found;
    int j;
    drive();
    #1;
    exp_vld = (m_in != 0) && s_axis_tvalid[m_cur];
    exp_rdy = '0;
    if (m_in != 0 && m_axis_tready) exp_rdy[m_cur] = 1'b1;
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_vld));
    chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
    chk("m_tid", 32'(m_axis_tid), 32'(m_cur));
    chk("busy", 32'(busy), 32'(m_in));
    chk("pkt_cnt", 32'(pkt_cnt), m_cnt % 65536);
    if (exp_vld) begin
      chk("m_tdata", m_axis_tdata, 32'(m_cur * 4096 + seq[m_cur]));
      chk("m_tlast", 32'(m_axis_tlast), 32'(rem[m_cur] == 1));
    end
    vq.push_back(int'(m_axis_tvalid));
    tidq.push_back(int'(m_axis_tid));
    if (busy) busy_n++;
    rdy_or |= s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      xq.push_back(int'(m_axis_tid));
      dq.push_back(m_axis_tdata);
      cq.push_back(tk);
      if (m_axis_tlast) pq.push_back(int'(m_axis_tid));
    end
    hs = s_axis_tvalid & s_axis_tready;
    // model: next owner is the first valid requester after the last one served
    if (!rst_n) begin
      model_reset();
    end else if (m_in == 0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM; k++) begin
        j = (m_prev + k) % NUM;
        if (!found && s_axis_tvalid[j]) begin m_cur = j; found = 1'b1; end
      end
      if (found) m_in = 1;
    end else if (s_axis_tvalid[m_cur] && m_axis_tready && s_axis_tlast[m_cur]) begin
      m_prev = m_cur; m_cnt++; m_in = 0;
      $display("pkt done: src %0d, packets %0d", m_prev, m_cnt);
    end
    for (int i = 0; i < NUM; i++) begin
      if (hs[i]) begin
        seq[i]++; rem[i]--;
        if (rem[i] == 0 && reload[i]) rem[i] = rnd[i] ? int'($urandom_range(1, 4)) : len[i];
      end
    end
    @(posedge clk);
    #1;
    tk++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr[6];
    int exp_cq[4];
    int exp_xq[4];
    int exp_ws[4];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp_cq = '{1, 7, 8, 10};
    exp_xq = '{3, 3, 3, 0};
    exp_ws = '{1, 3, 1, 3};

    rst_n = 1'b0; m_axis_tready = 1'b0;
    src_clear(); drive();
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;

    // Reset values and single requester, 3-beat packet
    m_axis_tready = 1'b1;
    do_reset(); clr_log();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(pkt_cnt), 0);
    chk("rst_tid", 32'(m_axis_tid), 0);
    chk("rst_rdy", 32'(s_axis_tready), 0);
    chk("rst_vld", 32'(m_axis_tvalid), 0);
    src_set(2, 3, 1'b0);
    repeat (6) tick();
    chk("single_lat0", 32'(vq[0]), 0);
    chk("single_lat1", 32'(vq[1]), 1);
    chk("single_nbeats", 32'(xq.size()), 3);
    for (int i = 0; i < 3 && i < xq.size(); i++) begin
      chk("single_tid", 32'(xq[i]), 2);
      chk("single_data", dq[i], 32'(2 * 4096 + i));
    end
    chk("single_cnt", 32'(pkt_cnt), 1);
    chk("single_busy", 32'(busy_n), 3);

    // Round-robin fairness: all requesters, 2-beat packets back to back
    src_clear(); do_reset(); clr_log();
    for (int i = 0; i < NUM; i++) src_set(i, 2, 1'b1);
    repeat (18) tick();
    chk("rr_npkts", 32'(pq.size()), 6);
    for (int i = 0; i < 6 && i < pq.size(); i++) chk("rr_order", 32'(pq[i]), 32'(exp_rr[i]));
    chk("rr_cnt", 32'(pkt_cnt), 6);

    // Back-pressure on a 4-beat packet from requester 1
    src_clear(); do_reset(); clr_log();
    src_set(1, 4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      m_axis_tready = (i % 2 == 0);
      tick();
    end
    m_axis_tready = 1'b1;
    chk("bp_nbeats", 32'(xq.size()), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) chk("bp_data", dq[i], 32'(4096 + i));
    chk("bp_rdy_only1", 32'(rdy_or), 32'b0010);
    chk("bp_cnt", 32'(pkt_cnt), 1);

    // No preemption: requester 3 stalls mid-packet while requester 0 waits
    src_clear(); do_reset(); clr_log();
    src_set(3, 3, 1'b0);
    tick();
    src_set(0, 1, 1'b0);
    tick();
    gate[3] = 1'b0;
    repeat (5) tick();
    gate[3] = 1'b1;
    repeat (6) tick();
    for (int i = 2; i <= 6; i++) chk("np_hold_tid", 32'(tidq[i]), 3);
    chk("np_nbeats", 32'(cq.size()), 4);
    for (int i = 0; i < 4 && i < cq.size(); i++) begin
      chk("np_cycle", 32'(cq[i]), 32'(exp_cq[i]));
      chk("np_tid", 32'(xq[i]), 32'(exp_xq[i]));
    end

    // Reset mid-packet after two beats of a 4-beat packet from requester 2
    src_clear(); do_reset(); clr_log();
    src_set(2, 4, 1'b0);
    repeat (3) tick();
    do_reset();
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_cnt", 32'(pkt_cnt), 0);
    chk("mrst_rdy", 32'(s_axis_tready), 0);
    chk("mrst_tid", 32'(m_axis_tid), 0);
    src_clear(); clr_log();
    src_set(0, 2, 1'b0);
    src_set(2, 2, 1'b0);
    repeat (4) tick();
    chk("mrst_nbeats", 32'(xq.size()), 2);
    if (xq.size() > 0) chk("mrst_first", 32'(xq[0]), 0);

    // Wrap and skip: only requesters 1 and 3
    src_clear(); do_reset(); clr_log();
    src_set(1, 1, 1'b1);
    src_set(3, 1, 1'b1);
    repeat (8) tick();
    chk("ws_npkts", 32'(pq.size()), 4);
    for (int i = 0; i < 4 && i < pq.size(); i++) chk("ws_order", 32'(pq[i]), 32'(exp_ws[i]));

    // Randomized traffic with stalls, back-pressure and occasional reset
    src_clear(); do_reset(); clr_log();
    for (int i = 0; i < NUM; i++) begin
      rnd[i] = 1'b1; reload[i] = 1'b1; rem[i] = int'($urandom_range(1, 4));
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM; i++) gate[i] = ($urandom_range(0, 3) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_rr_arb.md
# axis_rr_arb

Packet-granular round-robin arbiter that shares one downstream AXI-stream channel (typically the slave side of an `axis_s` buffer) among NUM upstream AXI-stream masters. It grants one requester at a time and holds the grant until that requester's `tlast` beat is accepted. Only then does it re-arbitrate, so packets are never interleaved. The granted source index is forwarded on `m_axis_tid` so downstream logic can demultiplex.

## Interface

**Parameters**

- `WIDTH`, 32: data width per beat.
- `NUM`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(NUM)`: width of the grant index. Derived; do not override.

**Ports**

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  NUM*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `s_axis_tvalid`  in  NUM  per-requester valid.
- `s_axis_tlast`  in  NUM  per-requester end-of-packet.
- `s_axis_tready`  out  NUM  per-requester ready; at most one bit is set at any time.
- `m_axis_tdata`  out  WIDTH  granted data.
- `m_axis_tvalid`  out  1  granted valid.
- `m_axis_tlast`  out  1  granted last.
- `m_axis_tid`  out  IDW  index of the granted requester.
- `m_axis_tready`  in  1  downstream ready.
- `busy`  out  1  high while a packet is in progress (state BUSY).
- `pkt_cnt`  out  16  count of completed packets; wraps at 2^16.

## Operation

- **State machine:** two states, IDLE and BUSY. The `grant` register (IDW bits) and the `last` register (IDW bits) select the requester.
- **IDLE**
  - Outputs: `m_axis_tvalid`=0 and all `s_axis_tready`=0.
  - If any `s_axis_tvalid` bit is high, select the first requester with valid high, searching upward from (`last`+1) mod NUM with wrap-around. Load it into `grant` and go to BUSY.
  - If no `s_axis_tvalid` bit is high, stay in IDLE.
- **BUSY**
  - Forwarding: `m_axis_tvalid`=`s_axis_tvalid[grant]`, `m_axis_tdata`=`s_axis_tdata[grant]`, `m_axis_tlast`=`s_axis_tlast[grant]`.
  - Ready: `s_axis_tready[grant]`=`m_axis_tready`; every other ready bit is 0.
  - A beat transfers when `m_axis_tvalid` && `m_axis_tready`.
  - On a transfer with `m_axis_tlast`=1: `last`<=`grant`, `pkt_cnt`<=`pkt_cnt`+1, and the state returns to IDLE.
  - Otherwise the state stays in BUSY, and requests from other inputs are ignored.
- **Grant stability:**
  - The granted requester dropping `tvalid` mid-packet does not release the grant.
  - The grant releases only on an accepted `tlast` beat.
- **Outputs outside BUSY:**
  - `m_axis_tdata`, `m_axis_tlast` and `m_axis_tid` are always driven from `grant` and are don't-care while `m_axis_tvalid`=0.
  - `m_axis_tid` equals `grant` in both states.
- **Fairness:** with all NUM requesters continuously requesting, grants rotate 0,1,...,NUM-1,0,...
- **Combinational paths:** the datapath is purely combinational from the `s_axis_*` inputs to `m_axis_*`, and from `m_axis_tready` to `s_axis_tready`. No data is buffered inside this block.

## Timing

- **Reset values** (`rst_n` low at a rising edge):
  - State IDLE, `grant`=0, `last`=NUM-1, so requester 0 wins first.
  - `pkt_cnt`=0, `busy`=0, `m_axis_tvalid`=0, all `s_axis_tready`=0, `m_axis_tid`=0.
- **Arbitration latency:**
  - The cycle a request is seen in IDLE is spent arbitrating.
  - The first beat can transfer in the following cycle.
- **Inter-packet bubble:** exactly one idle cycle between the accepted `tlast` beat and the first beat of the next packet, including the case where the same requester continues.
- **Simultaneous events:** a new request arriving in the same cycle as an accepted `tlast` beat is evaluated in the following IDLE cycle against the updated `last`.
- **Single-beat packets:** `tlast`=1 on the first beat gives 1 transfer cycle plus 1 arbitration cycle, so at most one packet per 2 cycles.
- **Reset mid-packet:**
  - The packet in progress is abandoned.
  - No ready is asserted in the cycle after reset.
  - The partial packet is not counted.
- **`pkt_cnt` overflow:** 0xFFFF + 1 -> 0x0000 with no flag.

## Test plan

- **Single requester:** NUM=4; only requester 2 sends a 3-beat packet (A,B,C, with `tlast` on C) and `m_axis_tready`=1 throughout.
  - `m_axis_tvalid` rises 1 cycle after `tvalid[2]` rises.
  - Output is A,B,C on consecutive cycles with `m_axis_tid`=2.
  - `pkt_cnt`=1 afterwards; `busy` is high for 3 cycles.
- **Round-robin fairness:** all 4 requesters continuously offer 2-beat packets.
  - Grant order is 0,1,2,3,0,1.
  - Each packet takes 3 cycles (1 arbitration + 2 beats); `pkt_cnt`=6 after 18 cycles.
- **Back-pressure:** `m_axis_tready` toggles 1,0,1,0 during a 4-beat packet from requester 1.
  - `s_axis_tready[1]` mirrors `m_axis_tready`.
  - No beats are lost or duplicated; `s_axis_tready[0,2,3]` stays 0 throughout.
- **No preemption:** requester 3 holds a packet open with `tvalid[3]`=0 for 5 cycles while requester 0 requests.
  - The grant stays at 3 for the whole gap.
  - Requester 0 is served only after 3's `tlast` beat is accepted plus 1 bubble cycle.
- **Reset mid-packet:** assert `rst_n`=0 for 1 cycle after beat 2 of a 4-beat packet from requester 2.
  - Next cycle: `busy`=0, `pkt_cnt`=0, all readies 0, `m_axis_tid`=0.
  - The next arbitration with requesters 0 and 2 both requesting grants requester 0.
- **Wrap and skip:** set `last`=3 and have only requesters 1 and 3 request.
  - Grant order is 1,3,1,3.
